// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Owns the architectural program counter and sequences instruction fetch
// against a request/ready instruction memory port. Each completed handshake
// advances the PC to either PC+1 (wrapping) or the branch target. Every taken
// branch is followed by a single flush bubble. Fetch stops for good when the
// PC would be loaded with HALT_ADDR; only reset leaves the halted state.
//
// Ports
//   clock           in   1           rising-edge clock
//   reset           in   1           asynchronous, active-high reset
//   branch_sig      in   1           branch taken for the instruction being fetched
//   branch_address  in   ADDR_WIDTH  branch target
//   stall           in   1           pipeline hold request from downstream
//   imem_ready      in   1           instruction memory has data for pc
//   pc              out  ADDR_WIDTH  current fetch address (registered)
//   imem_req        out  1           fetch request for pc
//   fetch_valid     out  1           fetch of pc completes this cycle
//   flush           out  1           bubble cycle after a taken branch
//   halted          out  1           sequencer stopped at HALT_ADDR
//   fetch_count     out  CNT_WIDTH   number of completed fetches (wrapping)
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter int unsigned              ADDR_WIDTH   = 10,
    parameter logic [ADDR_WIDTH-1:0]    RESET_VECTOR = '0,
    parameter logic [ADDR_WIDTH-1:0]    HALT_ADDR    = ADDR_WIDTH'(160),
    parameter int unsigned              CNT_WIDTH    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  branch_sig,
    input  logic [ADDR_WIDTH-1:0] branch_address,
    input  logic                  stall,
    input  logic                  imem_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  imem_req,
    output logic                  fetch_valid,
    output logic                  flush,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH,
        S_HALT
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    // Handshake completion for the current cycle, shared by both comb processes.
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] pc_next;

    // -----------------------------------------------------------------------
    // State register (state, PC and retired-fetch counter)
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VECTOR;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;

        // Natural truncation to ADDR_WIDTH gives the 2^ADDR_WIDTH wrap.
        pc_inc  = pc_q + ADDR_WIDTH'(1);
        pc_next = branch_sig ? branch_address : pc_inc;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                // Stall and imem_ready=0 both fall through with everything held;
                // branch_sig only matters on a completed handshake.
                if (handshake) begin
                    count_d = count_q + CNT_WIDTH'(1);
                    if (pc_next == HALT_ADDR) begin
                        // PC keeps the address of the last fetched instruction.
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_next;
                        state_d = branch_sig ? S_FLUSH : S_FETCH;
                    end
                end
            end

            S_FLUSH: begin
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        imem_req    = (state_q == S_FETCH);
        handshake   = (state_q == S_FETCH) & imem_ready & ~stall;
        fetch_valid = handshake;
        flush       = (state_q == S_FLUSH);
        halted      = (state_q == S_HALT);
        pc          = pc_q;
        fetch_count = count_q;
    end

endmodule
